// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, command entry layout, group selects.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_IRQCLR = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  typedef struct packed {
    logic       sel;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  localparam logic ALU_SEL_A = 1'b0;
  localparam logic ALU_SEL_B = 1'b1;

  localparam int ALU_CMD_W = $bits(alu_cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu_cmd_t with registered full/empty flags and a zero-latency head.
// Pushes while full and pops while empty are dropped; pointers wrap modulo DEPTH.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push_i,
  input  alu_cmd_t push_dat_i,
  input  logic     pop_i,
  output alu_cmd_t head_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  alu_cmd_t      mem_q [DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          full_q;
  logic          empty_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + AW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == CNT_FULL);
      empty_q <= (count_d == '0);
    end
  end

  // Storage is not reset; the empty flag guards every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= push_dat_i;
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Buffers ALU commands, issues one at a time, captures alu_out ALU_LAT cycles after issue,
// clears alu_irq when it was seen at capture, and returns one in-order response per command.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_sel,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_irq,
  output logic       alu_enable,
  output logic       alu_enable_a,
  output logic       alu_enable_b,
  output logic [1:0] alu_op_a,
  output logic [1:0] alu_op_b,
  output logic [7:0] alu_in_a,
  output logic [7:0] alu_in_b,
  input  logic [7:0] alu_out,
  input  logic       alu_irq,
  output logic       alu_irq_clr
);

  if (ALU_LAT < 1 || ALU_LAT > 7) begin : g_bad_lat
    $error("alu_cmd_sequencer: ALU_LAT must be within 1..7");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("alu_cmd_sequencer: DEPTH must be a power of two >= 2");
  end

  localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT - 1);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] lat_cnt_q;
  logic [2:0] lat_cnt_d;
  logic [7:0] rsp_data_q;
  logic [7:0] rsp_data_d;
  logic       rsp_irq_q;
  logic       rsp_irq_d;

  alu_cmd_t   cmd_in;
  alu_cmd_t   head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       capture;
  logic       issue;

  assign cmd_in    = {cmd_sel, cmd_op, cmd_a, cmd_b};
  assign cmd_ready = !fifo_full && !rst;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ST_ISSUE);
  assign capture   = (state_q == ST_WAIT) && (lat_cnt_q == 3'd0);

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (cmd_in),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_irq_d  = rsp_irq_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // alu_irq is only meaningful in the capture cycle; elsewhere it is ignored.
        if (capture) begin
          rsp_data_d = alu_out;
          rsp_irq_d  = alu_irq;
          state_d    = alu_irq ? ST_IRQCLR : ST_RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end
      end
      ST_IRQCLR: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      lat_cnt_q  <= 3'd0;
      rsp_data_q <= 8'h00;
      rsp_irq_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_cnt_q  <= lat_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_irq_q  <= rsp_irq_d;
    end
  end

  // Outputs are forced low while rst is high so a reset mid-issue never leaks a command.
  assign issue        = (state_q == ST_ISSUE) && !rst;
  assign alu_enable   = issue;
  assign alu_enable_a = issue && (head.sel == ALU_SEL_A);
  assign alu_enable_b = issue && (head.sel == ALU_SEL_B);
  assign alu_op_a     = alu_enable_a ? head.op : 2'b00;
  assign alu_op_b     = alu_enable_b ? head.op : 2'b00;
  assign alu_in_a     = issue ? head.a : 8'h00;
  assign alu_in_b     = issue ? head.b : 8'h00;

  assign alu_irq_clr  = (state_q == ST_IRQCLR) && !rst;
  assign rsp_valid    = (state_q == ST_RESP) && !rst;
  assign rsp_data     = rst ? 8'h00 : rsp_data_q;
  assign rsp_irq      = rsp_irq_q && !rst;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer at ALU_LAT=1 and ALU_LAT=3: directed cases plus random traffic
// scored against a transaction-level model of push, issue, capture and response timing.
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;

  typedef struct {
    logic       sel;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         t;
  } pend_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string what, input int lat, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL [LAT=%0d] %s at cycle %0d: got 0x%0h, expected 0x%0h", lat, what, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int x);
    while (cyc < x) step();
  endtask

  // Behaviour of the ALU the bench pretends to be.
  function automatic logic [7:0] alu_fn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic irq_fn(input logic [7:0] r);
    return r[7:5] == 3'b111;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lat
    localparam int LAT = (g == 0) ? 1 : 3;

    logic       rst, cmd_valid, cmd_ready, cmd_sel, rsp_valid, rsp_ready, rsp_irq;
    logic [1:0] cmd_op, alu_op_a, alu_op_b;
    logic [7:0] cmd_a, cmd_b, rsp_data, alu_in_a, alu_in_b, alu_out;
    logic       alu_enable, alu_enable_a, alu_enable_b, alu_irq, alu_irq_clr;

    pend_t      pending[$];
    pend_t      cur;
    int         fifo_cnt = 0;
    bit         in_flight = 0;
    int         issue_cyc = 0;
    int         last_hs = -100;
    logic [7:0] exp_res = 8'h00;
    bit         exp_irq = 0;
    bit         exp_issue, exp_valid;
    int         resp_count = 0;
    int         issue_cnt = 0;
    int         clr_cnt = 0;
    bit         alu_sched = 0;
    int         alu_due = 0;
    logic [7:0] alu_val = 8'h00;
    bit         alu_irqv = 0;
    bit         fin = 0;

    alu_cmd_sequencer #(
      .DEPTH   (DEPTH),
      .ALU_LAT (LAT)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_sel      (cmd_sel),
      .cmd_op       (cmd_op),
      .cmd_a        (cmd_a),
      .cmd_b        (cmd_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_irq      (rsp_irq),
      .alu_enable   (alu_enable),
      .alu_enable_a (alu_enable_a),
      .alu_enable_b (alu_enable_b),
      .alu_op_a     (alu_op_a),
      .alu_op_b     (alu_op_b),
      .alu_in_a     (alu_in_a),
      .alu_in_b     (alu_in_b),
      .alu_out      (alu_out),
      .alu_irq      (alu_irq),
      .alu_irq_clr  (alu_irq_clr)
    );

    // ALU stand-in: the true result appears only in the cycle ALU_LAT after issue; noise otherwise.
    initial begin
      alu_out = 8'h00;
      alu_irq = 1'b0;
      forever begin
        step();
        if (alu_sched && cyc == alu_due) begin
          alu_out = alu_val;
          alu_irq = alu_irqv;
        end else begin
          alu_out = 8'($urandom);
          alu_irq = 1'($urandom_range(0, 1));
        end
      end
    end

    // Model and compare, once per cycle on the falling edge.
    always @(negedge clk) begin
      if (rst) begin
        chk("reset_alu_bus", LAT, 32'({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b}), 32'd0);
        chk("reset_rsp", LAT, 32'({rsp_valid, rsp_irq, rsp_data, alu_irq_clr, cmd_ready}), 32'd0);
        pending.delete();
        fifo_cnt  = 0;
        in_flight = 0;
        last_hs   = -100;
        alu_sched = 0;
      end else begin
        chk("cmd_ready", LAT, 32'(cmd_ready), 32'(fifo_cnt < DEPTH));
        exp_issue = !in_flight && pending.size() > 0 && cyc >= pending[0].t + 2 && cyc >= last_hs + 2;
        chk("alu_enable", LAT, 32'(alu_enable), 32'(exp_issue));
        if (exp_issue) begin
          cur = pending.pop_front();
          fifo_cnt--;
          issue_cnt++;
          chk("issue_bus", LAT,
              32'({alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b}),
              32'({~cur.sel, cur.sel, (cur.sel ? 2'b00 : cur.op), (cur.sel ? cur.op : 2'b00), cur.a, cur.b}));
          exp_res   = alu_fn(cur.op, cur.a, cur.b);
          exp_irq   = irq_fn(exp_res);
          issue_cyc = cyc;
          in_flight = 1;
          alu_sched = 1;
          alu_due   = cyc + LAT;
          alu_val   = exp_res;
          alu_irqv  = exp_irq;
        end else begin
          chk("idle_alu_bus", LAT, 32'({alu_enable_a, alu_enable_b, alu_op_a, alu_op_b, alu_in_a, alu_in_b}), 32'd0);
        end
        chk("alu_irq_clr", LAT, 32'(alu_irq_clr), 32'(in_flight && exp_irq && cyc == issue_cyc + LAT + 1));
        exp_valid = in_flight && cyc >= issue_cyc + LAT + 1 + (exp_irq ? 1 : 0);
        chk("rsp_valid", LAT, 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
          chk("rsp_data", LAT, 32'(rsp_data), 32'(exp_res));
          chk("rsp_irq", LAT, 32'(rsp_irq), 32'(exp_irq));
          if (rsp_ready) begin
            in_flight = 0;
            last_hs   = cyc;
            resp_count++;
          end
        end
        if (alu_irq_clr) clr_cnt++;
        if (cmd_valid && cmd_ready) begin
          pending.push_back('{cmd_sel, cmd_op, cmd_a, cmd_b, cyc});
          fifo_cnt++;
        end
      end
    end

    initial begin
      int t, acc, rc, ic;
      rst = 1'b1; cmd_valid = 1'b0; cmd_sel = 1'b0; cmd_op = 2'd0;
      cmd_a = 8'h00; cmd_b = 8'h00; rsp_ready = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", LAT, 32'(cmd_ready), 32'd1);

      // Group A add: 0x12 + 0x34 = 0x46, no irq.
      step();
      t = cyc;
      cmd_valid = 1'b1; cmd_sel = 1'b0; cmd_op = 2'd2; cmd_a = 8'h12; cmd_b = 8'h34;
      step();
      cmd_valid = 1'b0;
      goto_cyc(t + 2); @(negedge clk);
      chk("d1_issue", LAT, 32'({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b}),
          32'({1'b1, 1'b1, 1'b0, 2'd2, 2'd0}));
      goto_cyc(t + 2 + LAT); @(negedge clk);
      chk("d1_rsp_early", LAT, 32'(rsp_valid), 32'd0);
      goto_cyc(t + 3 + LAT); @(negedge clk);
      chk("d1_rsp", LAT, 32'({rsp_valid, rsp_irq, rsp_data}), 32'({1'b1, 1'b0, 8'h46}));
      goto_cyc(t + 8 + LAT);
      chk("d1_no_clr", LAT, 32'(clr_cnt), 32'd0);

      // Group B OR giving 0xFF, which raises irq.
      t = cyc;
      cmd_valid = 1'b1; cmd_sel = 1'b1; cmd_op = 2'd1; cmd_a = 8'hF0; cmd_b = 8'h0F;
      step();
      cmd_valid = 1'b0;
      goto_cyc(t + 2); @(negedge clk);
      chk("d2_issue", LAT, 32'({alu_enable, alu_enable_a, alu_enable_b, alu_op_a, alu_op_b}),
          32'({1'b1, 1'b0, 1'b1, 2'd0, 2'd1}));
      goto_cyc(t + 3 + LAT); @(negedge clk);
      chk("d2_clr", LAT, 32'({alu_irq_clr, rsp_valid}), 32'({1'b1, 1'b0}));
      goto_cyc(t + 4 + LAT); @(negedge clk);
      chk("d2_rsp", LAT, 32'({rsp_valid, rsp_irq, rsp_data, alu_irq_clr}), 32'({1'b1, 1'b1, 8'hFF, 1'b0}));
      goto_cyc(t + 10 + LAT);
      chk("d2_clr_count", LAT, 32'(clr_cnt), 32'd1);

      // Fill with the consumer stalled: four FIFO slots plus the one already popped.
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 8; i++) begin
        cmd_valid = 1'b1; cmd_sel = 1'($urandom); cmd_op = 2'($urandom);
        cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        @(negedge clk);
        if (cmd_valid && cmd_ready) acc++;
        if (i == 5) chk("d3_full", LAT, 32'(cmd_ready), 32'd0);
        step();
      end
      cmd_valid = 1'b0;
      chk("d3_accepted", LAT, 32'(acc), 32'd5);
      rc = resp_count;
      repeat (10) step();
      rsp_ready = 1'b1;
      goto_cyc(cyc + 5 * (LAT + 4) + 8);
      chk("d3_drained", LAT, 32'(resp_count - rc), 32'd5);

      // Reset while the first of three commands is in WAIT.
      t = cyc;
      for (int i = 0; i < 3; i++) begin
        cmd_valid = 1'b1; cmd_sel = 1'($urandom); cmd_op = 2'($urandom);
        cmd_a = 8'($urandom); cmd_b = 8'($urandom);
        step();
      end
      cmd_valid = 1'b0;
      rst = 1'b1;
      rc = resp_count;
      ic = issue_cnt;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("d4_after_rst", LAT, 32'({cmd_ready, alu_enable, rsp_valid}), 32'({1'b1, 1'b0, 1'b0}));
      goto_cyc(cyc + 12);
      chk("d4_flushed", LAT, 32'({16'(resp_count - rc), 16'(issue_cnt - ic)}), 32'd0);
      t = cyc;
      cmd_valid = 1'b1; cmd_sel = 1'($urandom); cmd_op = 2'($urandom);
      cmd_a = 8'($urandom); cmd_b = 8'($urandom);
      step();
      cmd_valid = 1'b0;
      goto_cyc(t + 6 + LAT);
      chk("d4_resume", LAT, 32'(resp_count - rc), 32'd1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
        rst       = ($urandom_range(0, 249) == 0);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_sel   = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        rsp_ready = ($urandom_range(0, 9) < 7);
        step();
      end
      rst = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
      goto_cyc(cyc + 6 * (LAT + 4) + 10);
      chk("random_drained", LAT, 32'(pending.size() + (in_flight ? 1 : 0)), 32'd0);
      fin = 1'b1;
    end
  end

  initial begin
    for (int i = 0; i < 20000 && !(g_lat[0].fin && g_lat[1].fin); i++) @(posedge clk);
    if (!(g_lat[0].fin && g_lat[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout: stimulus did not complete, done flags %0d %0d, required 1 1",
               g_lat[0].fin, g_lat[1].fin);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
